// File: rtl/m_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// default geometry and address-field width helpers.
package m_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REFILL    = 2'd1,
    S_FILL_DONE = 2'd2
  } cache_state_e;

  localparam int C_ADDR_W = 12;
  localparam int C_DATA_W = 32;
  localparam int C_IDX_W  = 6;
  localparam int C_OFS_W  = 2;
  localparam int C_CNT_W  = 32;

  function automatic int tag_w(input int addr_w, input int idx_w, input int ofs_w);
    return addr_w - idx_w - ofs_w;
  endfunction

  // Line address = tag and index, i.e. the word address without its offset.
  function automatic int line_w(input int addr_w, input int ofs_w);
    return addr_w - ofs_w;
  endfunction

endpackage

// File: rtl/m_sat_counter.sv
// Saturating up-counter used for the cache performance counters; holds at
// all-ones instead of wrapping.
module m_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_inc,
  output logic [CNT_W-1:0] w_value
);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_value <= '0;
    end else if (w_inc && (w_value != '1)) begin
      w_value <= w_value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/m_icache_dm.sv
// Direct-mapped read-only instruction cache with zero-latency hits, a
// line-refill FSM towards a handshaked backing memory, flush and counters.
module m_icache_dm
  import m_cache_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W,
  parameter int IDX_W  = C_IDX_W,
  parameter int OFS_W  = C_OFS_W,
  parameter int CNT_W  = C_CNT_W
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_rdata,
  output logic              w_ready,
  input  logic              w_flush,
  output logic              w_mem_req,
  output logic [ADDR_W-1:0] w_mem_addr,
  input  logic              w_mem_ack,
  input  logic [DATA_W-1:0] w_mem_rdata,
  output logic [CNT_W-1:0]  w_hits,
  output logic [CNT_W-1:0]  w_misses
);

  localparam int TAG_W  = tag_w(ADDR_W, IDX_W, OFS_W);
  localparam int LINE_W = line_w(ADDR_W, OFS_W);
  localparam int NLINES = 2 ** IDX_W;
  localparam int NWORDS = 2 ** (IDX_W + OFS_W);
  localparam logic [OFS_W-1:0] LAST_WORD = '1;

  cache_state_e      state_q, state_d;
  logic [NLINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_array  [NLINES];
  logic [DATA_W-1:0] data_array [NWORDS];
  logic [LINE_W-1:0] line_q;
  logic [OFS_W-1:0]  cnt_q, cnt_nxt;
  logic              pend_flush_q;

  logic [TAG_W-1:0]  req_tag, line_tag;
  logic [IDX_W-1:0]  req_idx, line_idx;
  logic              lookup_hit, miss_start, last_ack;

  assign req_tag  = w_addr[ADDR_W-1:IDX_W+OFS_W];
  assign req_idx  = w_addr[IDX_W+OFS_W-1:OFS_W];
  assign line_tag = line_q[LINE_W-1:IDX_W];
  assign line_idx = line_q[IDX_W-1:0];
  assign cnt_nxt  = cnt_q + OFS_W'(1);

  assign lookup_hit = w_req & valid_q[req_idx] & (tag_array[req_idx] == req_tag);
  assign w_rdata    = data_array[w_addr[IDX_W+OFS_W-1:0]];

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // A flush in the lookup cycle suppresses both the hit and a new refill.
  always_comb begin
    state_d    = state_q;
    w_ready    = 1'b0;
    miss_start = 1'b0;
    last_ack   = 1'b0;
    case (state_q)
      S_IDLE: begin
        w_ready = lookup_hit & ~w_flush;
        if (w_req && !lookup_hit && !w_flush) begin
          miss_start = 1'b1;
          state_d    = S_REFILL;
        end
      end
      S_REFILL: begin
        if (w_mem_ack && (cnt_q == LAST_WORD)) begin
          last_ack = 1'b1;
          state_d  = S_FILL_DONE;
        end
      end
      S_FILL_DONE: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      valid_q      <= '0;
      cnt_q        <= '0;
      pend_flush_q <= 1'b0;
      w_mem_req    <= 1'b0;
      w_mem_addr   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_flush) valid_q <= '0;
          if (miss_start) begin
            cnt_q      <= '0;
            w_mem_req  <= 1'b1;
            w_mem_addr <= {req_tag, req_idx, {OFS_W{1'b0}}};
          end
        end
        S_REFILL: begin
          if (w_flush) pend_flush_q <= 1'b1;
          if (w_mem_ack) begin
            cnt_q <= cnt_nxt;
            if (last_ack) w_mem_req  <= 1'b0;
            else          w_mem_addr <= {line_q, cnt_nxt};
          end
        end
        S_FILL_DONE: begin
          // A flush seen at any point during the refill discards the new line too.
          if (pend_flush_q || w_flush) valid_q <= '0;
          else                         valid_q[line_idx] <= 1'b1;
          pend_flush_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (miss_start) line_q <= {req_tag, req_idx};
    if ((state_q == S_REFILL) && w_mem_ack) begin
      data_array[{line_idx, cnt_q}] <= w_mem_rdata;
      if (last_ack) tag_array[line_idx] <= line_tag;
    end
  end

  m_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_inc   (w_ready),
    .w_value (w_hits)
  );

  m_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_inc   (miss_start),
    .w_value (w_misses)
  );

endmodule

// File: doc/m_icache_dm.md
Name: m_icache_dm

Overview:
- Parametrised direct-mapped, read-only instruction cache.
- Sits between the pipeline IF stage and a slow backing memory with a request/acknowledge handshake.
- Replaces the ideal asynchronous instruction memory, so multi-cycle memories can be used without changing IF timing on a hit.
- Adds a line-refill state machine, an invalidate/flush operation and hit/miss performance counters.

Parameters:
- ADDR_W, 12: word-address width (byte address bits [ADDR_W+1:2]).
- DATA_W, 32: instruction word width.
- IDX_W, 6: index bits; the cache holds 2^IDX_W lines.
- OFS_W, 2: word-offset bits; each line holds 2^OFS_W words.
- CNT_W, 32: performance counter width.

Ports:
- w_clk  in  1  clock, rising edge.
- w_rst_n  in  1  asynchronous active-low reset.
- w_req  in  1  fetch request valid.
- w_addr  in  ADDR_W  fetch word address; tag = [ADDR_W-1:IDX_W+OFS_W], index = [IDX_W+OFS_W-1:OFS_W], offset = [OFS_W-1:0].
- w_rdata  out  DATA_W  fetched instruction; valid when w_ready=1.
- w_ready  out  1  hit this cycle, w_rdata valid; IF must stall while w_req=1 and w_ready=0.
- w_flush  in  1  one-cycle pulse that invalidates all lines.
- w_mem_req  out  1  backing-memory read request.
- w_mem_addr  out  ADDR_W  backing-memory word address.
- w_mem_ack  in  1  backing memory returns w_mem_rdata this cycle.
- w_mem_rdata  in  DATA_W  refill data.
- w_hits  out  CNT_W  count of hit cycles.
- w_misses  out  CNT_W  count of refills started.

Behaviour:
- Reset (asynchronous, w_rst_n=0):
  - All valid bits cleared; FSM goes to IDLE.
  - w_mem_req=0, w_mem_addr=0, w_ready=0, w_hits=0, w_misses=0, pending-flush flag cleared.
  - Data and tag arrays are not reset.
- Lookup (IDLE state):
  - Combinational in the same cycle: hit = w_req & valid[index] & (tag_array[index]==tag).
  - w_ready = hit; w_rdata = data_array[index][offset].
  - Hit latency is 0 cycles, matching the current asynchronous memory.
  - w_rdata is don't-care when w_ready=0.
- FSM states: IDLE, REFILL, FILL_DONE.
- IDLE -> REFILL when w_req & ~hit & ~w_flush:
  - Capture the line base address (tag, index, offset=0).
  - Increment w_misses.
  - Next cycle: w_mem_req=1, w_mem_addr = base.
- REFILL:
  - w_mem_req stays 1 and w_mem_addr stable until w_mem_ack=1.
  - On ack: write w_mem_rdata to data_array[index][word counter], increment the counter, and present the next address in the following cycle. w_mem_req may remain high back-to-back.
  - After the last word is acked (counter wraps from 2^OFS_W-1 to 0): w_mem_req=0, write the tag, go to FILL_DONE.
- FILL_DONE (one cycle):
  - Set valid[index]=1 unless a flush is pending, then go to IDLE.
  - w_ready=0 in this state. The retried request hits on the next cycle.
  - Miss penalty with single-cycle ack = 2^OFS_W + 2 cycles from the miss cycle to the hit cycle.
- Changes to w_addr or w_req during REFILL are ignored. The refill always completes for the captured line, and the requester re-presents its address.
- w_flush:
  - In IDLE: all valid bits are cleared at the next edge, and w_ready is forced to 0 in the flush cycle.
  - In REFILL or FILL_DONE: the pending-flush flag is set. At FILL_DONE all valid bits are cleared, including the newly filled line; the flag is then cleared.
- Counters:
  - w_hits increments on every cycle with w_ready=1.
  - Both counters saturate at all-ones and never wrap.
- Reset asserted mid-refill: the FSM aborts immediately, w_mem_req drops asynchronously, and the partially filled line stays invalid.
- w_mem_ack outside REFILL is ignored.

Decomposition:
- Shared package m_cache_pkg holds:
  - FSM state encodings (S_IDLE=2'd0, S_REFILL=2'd1, S_FILL_DONE=2'd2).
  - Address-field width helper constants derived from ADDR_W/IDX_W/OFS_W.
- One natural sub-module, m_sat_counter (parameter CNT_W; ports: clock, reset, increment, value), instantiated twice for the performance counters.
- Tag/valid/data arrays stay inside m_icache_dm.

Test Plan:
- Cold miss:
  - Stimulus: reset, w_req=1, w_addr=12'h010, memory acks every cycle with data = address.
  - Required response: w_mem_req asserted for addresses 0x010..0x013; w_ready=1 with w_rdata=0x010 exactly 6 cycles after the request; w_misses=1.
- Hit streak:
  - Stimulus: after the above, w_addr = 0x011, 0x012, 0x013 on consecutive cycles.
  - Required response: w_ready=1 each cycle with data 0x011..0x013; w_mem_req stays 0; w_hits increments by 3.
- Conflict eviction:
  - Stimulus: fetch 0x010, then 0x110 (same index, different tag), then 0x010.
  - Required response: three refills, w_misses=3, correct data after each.
- Slow memory:
  - Stimulus: ack only every 3rd cycle.
  - Required response: w_mem_addr holds stable between acks; the line is filled correctly; w_ready stays 0 until after FILL_DONE.
- Flush during refill:
  - Stimulus: pulse w_flush in the second REFILL cycle.
  - Required response: the refill completes; the following request to the same address misses again (w_misses increments).
- Reset mid-refill:
  - Stimulus: deassert w_rst_n during REFILL.
  - Required response: w_mem_req=0 immediately, counters=0, and the next fetch to the same line misses.
